dual_mode_puf: RTL and testbench
================================

Name: dual_mode_puf

Overview:
- Deterministic, synthesizable behavioural model of a dual-mode physically unclonable function (PUF) with an N-stage challenge.
- One evaluation path behaves as an arbiter PUF (mode=0) or a ring-oscillator-comparison PUF (mode=1).
- Per-stage "process variation" comes from a seeded LFSR, so responses are repeatable in simulation.
- Sits as a leaf responder beside the challenge-generation logic; one 1-bit response per launch.

Parameters:
- N, 128, number of delay stages and challenge width (N ≥ 2).
- SEED, 16'hACE1, nonzero LFSR seed modelling the chip's variation fingerprint.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in  input  1  launch excitation, synchronous to clk; a rising edge starts an evaluation.
- mode  input  1  0 = arbiter mode, 1 = RO mode; sampled at launch.
- sel  input  N  challenge; sel[i] controls stage i; sampled at launch.
- out  output  1  response, held until the next evaluation completes.
- done  output  1  one-cycle pulse when out updates.

Behaviour:
- Reset (reset=0, asynchronous):
  - out=0, done=0, busy=0, in_q=0.
  - accumulators cleared; lfsr=SEED.
  - Reset mid-evaluation aborts it; out stays 0.
- Launch condition: in=1 and in_q=0 at a clk edge while idle.
  - in_q is in registered every clock.
  - Launches while busy are ignored, including edges of in during evaluation.
- On the launch edge E0:
  - capture sel and mode.
  - lfsr=SEED; D=0, SA=0, SB=0; stage index i=0; busy=1.
- LFSR: 16-bit right-shift Galois, polynomial mask 16'hB400.
  - step(x) = (x>>1) ^ (x[0] ? 16'hB400 : 0).
  - Stage i uses v = step applied i+1 times to SEED.
  - w[i] = v[3:0] as a signed 4-bit value.
  - p[i] = v[7:4] + 1, unsigned, range 1..16.
- Processing: at edges E1..EN, stage i = 0..N-1 is processed, one stage per clock.
- Arbiter mode:
  - if sel[i]=1 then D = -D; then D = D + w[i].
  - D is signed, width $clog2(N)+5.
- RO mode:
  - if sel[i]=1 then SA += p[i], else SB += p[i].
  - SA and SB are unsigned, width $clog2(N)+5; no overflow is possible.
- Completion at edge EN, using the stage N-1 result:
  - arbiter: out = (D_final < 0).
  - RO: out = (SA_final > SB_final); a tie gives 0.
  - done=1 for exactly one cycle; busy=0.
- Latency: out and done update N clocks after the launch edge.
  - Earliest relaunch is at EN+1; this requires in to have been seen low first.
- out does not change except at completion or reset.
- Same SEED, mode and sel always give the same out.

Decomposition:
- Package dual_mode_puf_pkg holds:
  - LFSR_POLY = 16'hB400.
  - function lfsr_step.
  - function acc_width(N).
  - mode enum {MODE_ARB=0, MODE_RO=1}.
- Optional sub-module puf_stage_gen: wraps the LFSR and emits w/p per step.
- The controller, accumulators and response register stay in the top.

Test Plan:
- Reset: hold reset=0 while toggling in → out=0, done=0; release, idle → out stays 0, no done.
- Arbiter, N=4, SEED=16'hACE1 (w=0,-8,-4,-2):
  - sel=4'b0000 → out=1 (D=-14).
  - sel=4'b1000 → out=0 (D=+10).
  - done pulses exactly 4 clocks after the launch edge.
- RO, N=4, SEED=16'hACE1 (p=8,4,10,5):
  - sel=4'b0011 → out=0 (12 vs 15).
  - sel=4'b1100 → out=1 (15 vs 12).
- Launch ignore: toggle in every cycle during a busy N=4 evaluation → exactly one done.
  - Result matches the sel/mode captured at launch, even though sel changes mid-run.
- Reset mid-operation: assert reset at E2 → out=0, no done.
  - A fresh launch afterwards gives the reference result above.
- N=128 random regression: 100 launches with random mode/sel.
  - out must match a software model using the same LFSR equations.
  - Repeating a challenge must give an identical response.

Source files
------------

// File: rtl/dual_mode_puf_pkg.sv
// Shared types and helpers for the dual-mode PUF.
// LFSR step, accumulator sizing, mode and state enums.
package dual_mode_puf_pkg;

  localparam logic [15:0] LFSR_POLY = 16'hB400;

  typedef enum logic {
    MODE_ARB = 1'b0,
    MODE_RO  = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [15:0] lfsr_step(
    input logic [15:0] x
  );
    return (x >> 1) ^ (x[0] ? LFSR_POLY : 16'h0000);
  endfunction

  function automatic int acc_width(input int n);
    return $clog2(n) + 5;
  endfunction

endpackage

// File: rtl/dual_mode_puf_stage_gen.sv
// Variation source: seeded Galois LFSR that yields
// one signed delay weight and one RO period per stage.
module puf_stage_gen
  import dual_mode_puf_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              adv,
  output logic signed [3:0] w,
  output logic        [4:0] p
);

  logic [15:0] lfsr;
  logic [15:0] v;

  // Stage value is always one step ahead of the register.
  always_comb begin
    v = lfsr_step(lfsr);
    w = signed'(v[3:0]);
    p = {1'b0, v[7:4]} + 5'd1;
  end

  // Reload the fingerprint on launch, walk one stage per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= SEED;
    end else if (load) begin
      lfsr <= SEED;
    end else if (adv) begin
      lfsr <= v;
    end
  end

endmodule

// File: rtl/dual_mode_puf.sv
// Dual-mode PUF responder: arbiter delay race or
// RO count comparison over N challenge stages.
module dual_mode_puf
  import dual_mode_puf_pkg::*;
#(
  parameter int          N    = 128,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in,
  input  logic         mode,
  input  logic [N-1:0] sel,
  output logic         out,
  output logic         done
);

  localparam int AW = acc_width(N);
  localparam int IW = $clog2(N);

  state_e state;
  state_e state_n;

  logic          in_q;
  logic [N-1:0]  sel_q;
  mode_e         mode_q;
  logic [IW-1:0] idx;

  logic signed [AW-1:0] d;
  logic        [AW-1:0] sa;
  logic        [AW-1:0] sb;

  logic signed [3:0]    w;
  logic        [4:0]    p;
  logic signed [AW-1:0] w_ext;
  logic        [AW-1:0] p_ext;
  logic signed [AW-1:0] d_neg;
  logic signed [AW-1:0] d_nx;
  logic        [AW-1:0] sa_nx;
  logic        [AW-1:0] sb_nx;

  logic bit_sel;
  logic run;
  logic launch;
  logic last;
  logic res;

  puf_stage_gen #(
    .SEED(SEED)
  ) u_gen (
    .clk  (clk),
    .reset(reset),
    .load (launch),
    .adv  (run),
    .w    (w),
    .p    (p)
  );

  // Control decode and next-state selection.
  always_comb begin
    state_n = state;
    run     = (state == ST_RUN);
    launch  = 1'b0;
    last    = 1'b0;
    unique case (1'b1)
      (state == ST_IDLE): begin
        launch = in & ~in_q;
        if (launch) state_n = ST_RUN;
      end
      (state == ST_RUN): begin
        last = (idx == IW'(N - 1));
        if (last) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Per-stage accumulator update and final decision.
  always_comb begin
    bit_sel = sel_q[idx];
    w_ext   = {{(AW - 4){w[3]}}, w};
    p_ext   = {{(AW - 5){1'b0}}, p};
    d_neg   = bit_sel ? -d : d;
    d_nx    = d_neg + w_ext;
    sa_nx   = bit_sel ? sa + p_ext : sa;
    sb_nx   = bit_sel ? sb : sb + p_ext;
    res     = (mode_q == MODE_RO) ?
              (sa_nx > sb_nx) : d_nx[AW-1];
  end

  // Controller state and edge detector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      in_q  <= 1'b0;
    end else begin
      state <= state_n;
      in_q  <= in;
    end
  end

  // Challenge capture and accumulators.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q  <= '0;
      mode_q <= MODE_ARB;
      idx    <= '0;
      d      <= '0;
      sa     <= '0;
      sb     <= '0;
    end else if (launch) begin
      sel_q  <= sel;
      mode_q <= mode_e'(mode);
      idx    <= '0;
      d      <= '0;
      sa     <= '0;
      sb     <= '0;
    end else if (run) begin
      idx <= idx + IW'(1);
      d   <= d_nx;
      sa  <= sa_nx;
      sb  <= sb_nx;
    end
  end

  // Response register and completion pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= last;
      if (last) out <= res;
    end
  end

endmodule

// File: tb/tb_dual_mode_puf.sv
// Bench for dual_mode_puf: directed N=4 cases and
// N=128 random challenges against a stage-sum model.
module tb_dual_mode_puf;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in4 = 1'b0;
  logic         mode4 = 1'b0;
  logic [3:0]   sel4 = '0;
  logic         out4;
  logic         done4;
  logic         in128 = 1'b0;
  logic         mode128 = 1'b0;
  logic [127:0] sel128 = '0;
  logic         out128;
  logic         done128;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dual_mode_puf #(.N(4), .SEED(16'hACE1)) u4 (
    .clk  (clk),
    .reset(reset),
    .in   (in4),
    .mode (mode4),
    .sel  (sel4),
    .out  (out4),
    .done (done4)
  );

  dual_mode_puf #(.N(128), .SEED(16'hACE1)) u128 (
    .clk  (clk),
    .reset(reset),
    .in   (in128),
    .mode (mode128),
    .sel  (sel128),
    .out  (out128),
    .done (done128)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  // Response from the stage rules, using plain integers.
  function automatic bit model(input int n,
                               input logic [127:0] s,
                               input bit m);
    logic [15:0] x;
    int dd, a, b, wi, pi;
    x = 16'hACE1;
    dd = 0; a = 0; b = 0;
    for (int i = 0; i < n; i++) begin
      x = (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
      wi = int'(x[3:0]);
      if (wi > 7) wi = wi - 16;
      pi = int'(x[7:4]) + 1;
      if (s[i]) begin
        dd = -dd;
        a = a + pi;
      end else begin
        b = b + pi;
      end
      dd = dd + wi;
    end
    return m ? (a > b) : (dd < 0);
  endfunction

  task automatic run4(input bit m, input logic [3:0] s,
                      input bit tog, input bit exp,
                      input string tag);
    int lat, nd;
    @(negedge clk);
    mode4 = m; sel4 = s; in4 = 1'b1;
    @(posedge clk);
    #1;
    in4 = 1'b0;
    lat = 0; nd = 0;
    for (int k = 1; k <= 10; k++) begin
      if (tog && k <= 3) begin
        in4 = k[0];
        sel4 = 4'($urandom);
        mode4 = 1'($urandom);
      end else begin
        in4 = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done4) begin
        nd++;
        if (lat == 0) lat = k;
      end
    end
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_ndone"}, nd, 1);
    chk({tag, "_out"}, out4, exp);
  endtask

  task automatic run128(input bit m,
                        input logic [127:0] s,
                        input string tag);
    int lat;
    bit exp;
    exp = model(128, s, m);
    @(negedge clk);
    mode128 = m; sel128 = s; in128 = 1'b1;
    @(posedge clk);
    #1;
    in128 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 140 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (done128) lat = k;
    end
    chk({tag, "_lat"}, lat, 128);
    chk({tag, "_out"}, out128, exp);
  endtask

  initial begin
    int nd;
    logic [127:0] s;
    bit m;

    // Reset held while in toggles.
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in4 = k[0];
      in128 = k[0];
    end
    #1;
    chk("rst_out4", out4, 0);
    chk("rst_done4", done4, 0);
    chk("rst_out128", out128, 0);
    @(negedge clk);
    in4 = 1'b0; in128 = 1'b0;
    reset = 1'b1;
    nd = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (done4 || done128) nd++;
    end
    chk("idle_done", nd, 0);
    chk("idle_out4", out4, 0);

    // Directed N=4 cases.
    run4(1'b0, 4'b0000, 1'b0, 1'b1, "arb0000");
    run4(1'b0, 4'b1000, 1'b0, 1'b0, "arb1000");
    run4(1'b1, 4'b0011, 1'b0, 1'b0, "ro0011");
    run4(1'b1, 4'b1100, 1'b0, 1'b1, "ro1100");

    // Launch ignore with sel/mode churn mid-run.
    run4(1'b0, 4'b1000, 1'b1, 1'b0, "ign");

    // Back to back relaunch gives the other answer.
    run4(1'b0, 4'b0000, 1'b0, 1'b1, "relaunch");

    // Abort at E2 with reset.
    @(negedge clk);
    mode4 = 1'b0; sel4 = 4'b0000; in4 = 1'b1;
    @(posedge clk);
    #1;
    in4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_out", out4, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    nd = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (done4) nd++;
    end
    chk("abort_ndone", nd, 0);
    chk("abort_out2", out4, 0);
    run4(1'b0, 4'b0000, 1'b0, 1'b1, "post_abort");
    run4(1'b1, 4'b1100, 1'b0, 1'b1, "post_abort_ro");

    // Random N=128 regression, each challenge repeated.
    for (int t = 0; t < 100; t++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      m = 1'($urandom);
      run128(m, s, "rnd");
      run128(m, s, "rep");
    end

    // Cross-check: all-zero challenge in both modes.
    run128(1'b0, '0, "zero_arb");
    run128(1'b1, '0, "zero_ro");
    chk("zero_ro_val", out128, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
